// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Fetch-stage pipeline controller. Owns the program counter,
//                arbitrates redirects, holds and memory stalls, and drives the
//                if_id / id_ex hold and flush controls. Also keeps saturating
//                counters of accepted redirects and of hold/stall cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      jump_addr_i,
  input  logic             jump_en_i,
  input  logic             hold_flag_i,
  input  logic             imem_ready_i,
  output logic [31:0]      pc_o,
  output logic             hold_if_id_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] jump_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_STALL = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             boot_q;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [31:0]      pc_inc;
  logic             jump_acc;
  logic             hold_req;
  logic             flush_if;
  logic             flush_ex;

  assign pc_inc = pc_q + 32'd4;

  // Next-state, next-PC and pipeline-register controls, in fixed priority:
  // boot cycle, redirect, execute hold, end of hold, memory stall, free run.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    jump_acc = 1'b0;
    hold_req = 1'b0;
    flush_if = 1'b0;
    flush_ex = 1'b0;
    if (boot_q) begin
      // First cycle out of reset: both pipeline registers take NOPs and the
      // PC stays at the reset address so the first fetch is issued cleanly.
      flush_if = 1'b1;
      flush_ex = 1'b1;
      state_d  = S_RUN;
    end else if (jump_en_i) begin
      jump_acc = 1'b1;
      pc_d     = {jump_addr_i[31:2], 2'b00};
      flush_if = 1'b1;
      flush_ex = 1'b1;
      state_d  = S_FLUSH;
    end else if (hold_flag_i) begin
      hold_req = 1'b1;
      flush_ex = 1'b1;
      state_d  = S_HOLD;
    end else if (state_q == S_HOLD) begin
      // Hold released: resume; if memory is not ready the fetch is not
      // accepted this cycle, so keep if_id and bubble id_ex.
      state_d = S_RUN;
      if (imem_ready_i) begin
        pc_d = pc_inc;
      end else begin
        hold_req = 1'b1;
        flush_ex = 1'b1;
      end
    end else if (!imem_ready_i) begin
      hold_req = 1'b1;
      flush_ex = 1'b1;
      state_d  = S_STALL;
    end else begin
      pc_d    = pc_inc;
      state_d = S_RUN;
    end
    // The instruction arriving in the cycle after a redirect was fetched from
    // the old path (one-cycle memory latency) and must always be discarded.
    if (!boot_q && state_q == S_FLUSH) begin
      flush_if = 1'b1;
    end
  end

  // Saturating event counters.
  always_comb begin
    jump_cnt_d  = jump_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (jump_acc && jump_cnt_q != CNT_MAX) begin
      jump_cnt_d = jump_cnt_q + CNT_ONE;
    end
    if ((state_q == S_HOLD || state_q == S_STALL) && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  assign misalign_d = jump_acc & (|jump_addr_i[1:0]);

  // State, PC, boot marker, misalign pulse and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_ADDR;
      boot_q      <= 1'b1;
      misalign_q  <= 1'b0;
      jump_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      boot_q      <= 1'b0;
      misalign_q  <= misalign_d;
      jump_cnt_q  <= jump_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_o          = pc_q;
  assign flush_if_id_o = flush_if;
  assign hold_if_id_o  = hold_req & ~flush_if;
  assign flush_id_ex_o = flush_ex;
  assign misalign_o    = misalign_q;
  assign jump_cnt_o    = jump_cnt_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl: directed scenarios then
//                randomized cycles against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int          CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] RADDR = 32'h0000_0000;

  typedef enum int {RUNNING, DRAINING, HELD, STARVED} mode_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      jump_addr_i = '0;
  logic             jump_en_i = 1'b0;
  logic             hold_flag_i = 1'b0;
  logic             imem_ready_i = 1'b1;
  logic [31:0]      pc_o;
  logic             hold_if_id_o;
  logic             flush_if_id_o;
  logic             flush_id_ex_o;
  logic             misalign_o;
  logic [CNT_W-1:0] jump_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;

  pipe_ctrl #(.RESET_ADDR(RADDR), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_addr_i  (jump_addr_i),
    .jump_en_i    (jump_en_i),
    .hold_flag_i  (hold_flag_i),
    .imem_ready_i (imem_ready_i),
    .pc_o         (pc_o),
    .hold_if_id_o (hold_if_id_o),
    .flush_if_id_o(flush_if_id_o),
    .flush_id_ex_o(flush_id_ex_o),
    .misalign_o   (misalign_o),
    .jump_cnt_o   (jump_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic        m_boot;
  mode_t       m_mode;
  logic [31:0] m_pc;
  logic        m_mis;
  int          m_jc, m_sc;
  logic        e_hold, e_fif, e_fex;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_mode = RUNNING; m_pc = RADDR; m_mis = 1'b0; m_jc = 0; m_sc = 0;
  endtask

  // Expected control outputs for the current cycle.
  task automatic model_outputs();
    logic draining;
    draining = !m_boot && m_mode == DRAINING;
    e_hold = 1'b0; e_fif = draining; e_fex = 1'b0;
    if (m_boot || jump_en_i) begin
      e_fif = 1'b1; e_fex = 1'b1;
    end else if (hold_flag_i || !imem_ready_i) begin
      // Keep if_id (unless the stale fetch is being flushed) and bubble id_ex,
      // except when a hold has just been released with memory ready.
      if (!(m_mode == HELD && !hold_flag_i && imem_ready_i)) begin
        e_fex  = 1'b1;
        e_hold = !draining;
      end
    end
  endtask

  // Advance the model by one clock edge.
  task automatic model_advance();
    mode_t nm;
    logic [31:0] npc;
    nm = RUNNING; npc = m_pc;
    if (!m_boot && (m_mode == HELD || m_mode == STARVED)) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    m_mis = 1'b0;
    if (m_boot) begin
      nm = RUNNING;
    end else if (jump_en_i) begin
      npc = jump_addr_i & ~32'd3;
      nm  = DRAINING;
      m_jc  = (m_jc < CMAX) ? m_jc + 1 : CMAX;
      m_mis = (jump_addr_i % 4) != 0;
    end else if (hold_flag_i) begin
      nm = HELD;
    end else if (m_mode == HELD) begin
      nm = RUNNING;
      if (imem_ready_i) npc = m_pc + 32'd4;
    end else if (!imem_ready_i) begin
      nm = STARVED;
    end else begin
      npc = m_pc + 32'd4;
    end
    m_boot = 1'b0; m_mode = nm; m_pc = npc;
  endtask

  task automatic check_all(input string tag);
    model_outputs();
    chk({tag, ":pc"},       pc_o,                   m_pc);
    chk({tag, ":hold_if"},  {31'd0, hold_if_id_o},  {31'd0, e_hold});
    chk({tag, ":flush_if"}, {31'd0, flush_if_id_o}, {31'd0, e_fif});
    chk({tag, ":flush_ex"}, {31'd0, flush_id_ex_o}, {31'd0, e_fex});
    chk({tag, ":misalign"}, {31'd0, misalign_o},    {31'd0, m_mis});
    chk({tag, ":jump_cnt"}, {28'd0, jump_cnt_o},    32'(m_jc));
    chk({tag, ":stall_cnt"},{28'd0, stall_cnt_o},   32'(m_sc));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input string tag, input logic j, input logic [31:0] a,
                      input logic h, input logic r);
    jump_en_i = j; jump_addr_i = a; hold_flag_i = h; imem_ready_i = r;
    #1;
    check_all(tag);
    model_advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    jump_en_i = 1'b0; hold_flag_i = 1'b0; imem_ready_i = 1'b1; jump_addr_i = '0;
    model_reset();
    #1;
    check_all("rst_a");
    @(negedge clk);
    #1;
    check_all("rst_b");
    rst = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // Reset release, free running: pc 0,0,4,8,C
    for (int i = 0; i < 5; i++) step("boot_run", 1'b0, 32'h0, 1'b0, 1'b1);
    // Redirect at pc 0x20 to 0x100
    step("j1c", 1'b1, 32'h1C, 1'b0, 1'b1);
    step("fl1c", 1'b0, 32'h0, 1'b0, 1'b1);
    step("j100", 1'b1, 32'h100, 1'b0, 1'b1);
    chk("jump_target", pc_o, 32'h100);
    step("fl100", 1'b0, 32'h0, 1'b0, 1'b1);
    step("run104", 1'b0, 32'h0, 1'b0, 1'b1);
    // Hold for 3 cycles at pc 0x40
    step("j3c", 1'b1, 32'h3C, 1'b0, 1'b1);
    step("fl3c", 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 32'h0, 1'b1, 1'b1);
    step("hold_rel", 1'b0, 32'h0, 1'b0, 1'b1);
    chk("hold_resume_pc", pc_o, 32'h44);
    step("run", 1'b0, 32'h0, 1'b0, 1'b1);
    // Jump and hold together, misaligned target
    step("jhold", 1'b1, 32'h202, 1'b1, 1'b1);
    step("fl_mis", 1'b0, 32'h0, 1'b0, 1'b1);
    step("run_mis", 1'b0, 32'h0, 1'b0, 1'b1);
    // Memory stall for 2 cycles, then jump during stall
    step("stall", 1'b0, 32'h0, 1'b0, 1'b0);
    step("stall", 1'b0, 32'h0, 1'b0, 1'b0);
    step("jstall", 1'b1, 32'h300, 1'b0, 1'b0);
    step("fl300", 1'b0, 32'h0, 1'b0, 1'b1);
    // PC wrap
    step("jwrap", 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
    step("flwrap", 1'b0, 32'h0, 1'b0, 1'b1);
    step("wrap", 1'b0, 32'h0, 1'b0, 1'b1);
    chk("pc_wrap", pc_o, 32'h0);
    // Reset mid-HOLD and mid-FLUSH
    step("h", 1'b0, 32'h0, 1'b1, 1'b1);
    step("h", 1'b0, 32'h0, 1'b1, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step("post_rst_h", 1'b0, 32'h0, 1'b0, 1'b1);
    step("jf", 1'b1, 32'h81, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step("post_rst_f", 1'b0, 32'h0, 1'b0, 1'b1);
    // Randomized traffic, including counter saturation and occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      if ($urandom_range(150) == 0) do_reset();
      else step("rand", ($urandom_range(7) == 0), a, ($urandom_range(5) == 0),
                ($urandom_range(4) != 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
